fft_frame_packer: RTL

//  Packs a free-running complex sample stream into fixed-length Avalon-ST frames for the FFT core.

---
 rtl/fft_frame_packer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fft_frame_packer.sv
// Buffers a free-running complex sample stream and emits fixed-length sop/eop framed
// Avalon-ST bursts to the FFT sink, while tracking frame alignment on the FFT source side.
module fft_frame_packer #(
  parameter int DW       = 8,
  parameter int LEN_LOG2 = 9,
  parameter int FIFO_AW  = 10,
  parameter int GAPLESS  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_real,
  input  logic [DW-1:0]       in_imag,
  output logic                in_ready,
  output logic                fft_sink_valid,
  output logic [DW-1:0]       fft_sink_real,
  output logic [DW-1:0]       fft_sink_imag,
  output logic                fft_sink_sop,
  output logic                fft_sink_eop,
  input  logic                fft_sink_ready,
  input  logic                fft_source_valid,
  input  logic                fft_source_sop,
  input  logic                fft_source_eop,
  output logic [LEN_LOG2-1:0] fft_in_cnt,
  output logic [LEN_LOG2-1:0] fft_out_cnt,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                overflow,
  output logic                frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] FRAME_LVL = (FIFO_AW + 1)'(1 << LEN_LOG2);
  localparam logic [LEN_LOG2-1:0] LAST_IDX = '1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [2*DW-1:0]    mem [DEPTH];
  logic [2*DW-1:0]    head;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_ptr_nxt;
  logic [FIFO_AW:0]   level_nxt;
  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               start;

  assign full           = (fifo_level == FULL_LVL);
  assign empty          = (fifo_level == '0);
  assign in_ready       = !full;
  assign push           = in_valid && !full;
  assign fft_sink_valid = (state == ST_STREAM) && !empty;
  assign pop            = fft_sink_valid && fft_sink_ready;
  assign fft_sink_sop   = fft_sink_valid && (fft_in_cnt == '0);
  assign fft_sink_eop   = fft_sink_valid && (fft_in_cnt == LAST_IDX);
  assign fft_sink_real  = head[2*DW-1:DW];
  assign fft_sink_imag  = head[DW-1:0];

  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt  = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + 1'b1;
    else if (pop && !push)
      level_nxt = fifo_level - 1'b1;
  end

  // The start test uses the post-update level so a frame can follow an eop with no idle cycle.
  always_comb begin
    start     = (GAPLESS != 0) ? (level_nxt >= FRAME_LVL) : (level_nxt != '0);
    state_nxt = state;
    if (state == ST_IDLE && start)
      state_nxt = ST_STREAM;
    else if (pop && fft_sink_eop)
      state_nxt = start ? ST_STREAM : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_real, in_imag};
  end

  // Head register pre-reads the next entry; a write landing on that slot is bypassed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      head       <= '0;
      overflow   <= 1'b0;
      state      <= ST_IDLE;
      fft_in_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      head       <= (push && wr_ptr == rd_ptr_nxt) ? {in_real, in_imag} : mem[rd_ptr_nxt];
      if (in_valid && full)
        overflow <= 1'b1;
      state <= state_nxt;
      if (pop)
        fft_in_cnt <= fft_in_cnt + 1'b1;
    end
  end

  // Source side: a misplaced sop or eop flags an error and resynchronises the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fft_out_cnt <= '0;
      frame_err   <= 1'b0;
    end else if (fft_source_valid) begin
      if (fft_source_sop && fft_out_cnt != '0) begin
        frame_err   <= 1'b1;
        fft_out_cnt <= LEN_LOG2'(1);
      end else if (fft_source_eop && fft_out_cnt != LAST_IDX) begin
        frame_err   <= 1'b1;
        fft_out_cnt <= '0;
      end else begin
        fft_out_cnt <= fft_out_cnt + 1'b1;
      end
    end
  end

endmodule
